// File: rtl/prach_ch_sched.sv
// Round-robin TDM scheduler for the PRACH long-sequence channel datapath.
// Define PRACH_SCHED_UNDERRUN_CNT_EN to build the saturating underrun counter.
//
// state | meaning
// IDLE  | slot counter held at 0, no strobes, waiting for en
// LOAD  | latch ch_mask, clear round counter, arm sync (one cycle)
// RUN   | one slot per cycle, en=0 requests a stop
// DRAIN | finish the current round, then IDLE
module prach_ch_sched #(
  parameter int SIZE        = 8,
  parameter int SYNC_PERIOD = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            resync,
  input  logic [SIZE-1:0] ch_mask,
  input  logic [SIZE-1:0] req,
  output logic [SIZE-1:0] gnt,
  output logic            dout_dv,
  output logic [7:0]      dout_chn,
  output logic            sync_out,
  output logic            busy,
  output logic [15:0]     underrun_cnt
);

  localparam int SW = (SIZE > 1) ? $clog2(SIZE) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_t;

  state_t          state, state_nx;
  logic [SW-1:0]   slot, slot_nx;
  logic [SIZE-1:0] mask_q, mask_nx, mask_eff;
  logic            sync_pend, sync_pend_nx;
  logic [15:0]     rnd_cnt, rnd_cnt_nx;
  logic            active, first_slot, last_slot;
  logic [SIZE-1:0] gnt_nx;
  logic            dv_nx, sync_nx, busy_nx;
  logic [7:0]      chn_nx;

  assign active     = (state == RUN) || (state == DRAIN);
  assign first_slot = (slot == '0);
  assign last_slot  = (slot == SW'(SIZE - 1));
  // The mask sampled on slot 0 already governs slot 0, so a new mask covers whole rounds.
  assign mask_eff   = first_slot ? ch_mask : mask_q;

  always_comb begin
    state_nx     = state;
    slot_nx      = slot;
    mask_nx      = mask_q;
    sync_pend_nx = sync_pend;
    rnd_cnt_nx   = rnd_cnt;
    gnt_nx       = '0;
    dv_nx        = 1'b0;
    sync_nx      = 1'b0;
    chn_nx       = 8'd0;
    case (state)
      IDLE: begin
        slot_nx = '0;
        if (en) state_nx = LOAD;
      end
      LOAD: begin
        mask_nx      = ch_mask;
        rnd_cnt_nx   = 16'd0;
        sync_pend_nx = 1'b1;
        slot_nx      = '0;
        state_nx     = RUN;
      end
      RUN, DRAIN: begin
        slot_nx = slot + 1'b1;
        chn_nx  = {{(8-SW){1'b0}}, slot};
        if (first_slot) mask_nx = ch_mask;
        if (mask_eff[slot] && req[slot]) begin
          gnt_nx[slot] = 1'b1;
          dv_nx        = 1'b1;
        end
        if (first_slot && sync_pend) begin
          sync_nx      = 1'b1;
          sync_pend_nx = 1'b0;
          rnd_cnt_nx   = 16'd0;
        end else if (last_slot) begin
          if (SYNC_PERIOD > 0 && rnd_cnt == 16'(SYNC_PERIOD - 1)) begin
            sync_pend_nx = 1'b1;
            rnd_cnt_nx   = 16'd0;
          end else begin
            rnd_cnt_nx = rnd_cnt + 16'd1;
          end
        end
        // Set wins over the slot-0 clear so a coincident resync re-arms.
        if (resync) sync_pend_nx = 1'b1;
        if (state == RUN && !en) state_nx = last_slot ? IDLE : DRAIN;
        else if (state == DRAIN && last_slot) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    busy_nx = (state_nx != IDLE) || active;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      slot      <= '0;
      mask_q    <= '0;
      sync_pend <= 1'b0;
      rnd_cnt   <= 16'd0;
      gnt       <= '0;
      dout_dv   <= 1'b0;
      dout_chn  <= 8'd0;
      sync_out  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nx;
      slot      <= slot_nx;
      mask_q    <= mask_nx;
      sync_pend <= sync_pend_nx;
      rnd_cnt   <= rnd_cnt_nx;
      gnt       <= gnt_nx;
      dout_dv   <= dv_nx;
      dout_chn  <= chn_nx;
      sync_out  <= sync_nx;
      busy      <= busy_nx;
    end
  end

`ifdef PRACH_SCHED_UNDERRUN_CNT_EN
  logic underrun_ev;
  assign underrun_ev = active && mask_eff[slot] && !req[slot];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) underrun_cnt <= 16'd0;
    else if (underrun_ev && underrun_cnt != 16'hFFFF) underrun_cnt <= underrun_cnt + 16'd1;
  end
`else
  assign underrun_cnt = 16'd0;
`endif

endmodule

// File: doc/prach_ch_sched.md
# prach_ch_sched

Round-robin TDM scheduler for the PRACH long-sequence channel datapath. Each channel buffer raises a request when a sample pair is ready. The block grants one channel per clock in fixed slot order 0..SIZE-1 and emits the matching `dv`/`chn`/`sync` control stream that drives the downstream channel-reshape stage. It also handles start/stop sequencing, periodic and on-demand sync generation, and underrun accounting.

## Interface
- `SIZE`, 8: channels per TDM round; power of two, 2..128.
- `SYNC_PERIOD`, 0: rounds between periodic sync pulses. 0 means sync only on start and on resync.
- `clk` in 1: clock. All logic is on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `en` in 1: run request, level-sensitive.
- `resync` in 1: single-cycle pulse requesting sync realignment.
- `ch_mask` in SIZE: channel enable bits; bit k enables slot k.
- `req` in SIZE: per-channel "sample pair available" flags.
- `gnt` out SIZE: one-hot pop strobe to channel buffers.
- `dout_dv` out 1: slot carries valid data.
- `dout_chn` out 8: slot index, zero-extended.
- `sync_out` out 1: round-start marker.
- `busy` out 1: state is not IDLE.
- `underrun_cnt` out 16: saturating count of starved enabled slots.

## Operation
- The FSM has four states: IDLE, LOAD, RUN, DRAIN.
- **IDLE**
  - Slot counter is held at 0.
  - All strobes are 0.
  - `en`=1 moves to LOAD.
- **LOAD** (exactly 1 cycle)
  - Latches `ch_mask` into `mask_q`.
  - Clears the round counter.
  - Arms `sync_pend`.
  - Moves to RUN.
- **RUN**
  - Slot counter `s` increments every cycle and wraps SIZE-1→0.
  - `mask_q` is re-latched from `ch_mask` at `s`=0. A mask change therefore takes effect at the next round boundary, never mid-round.
  - Per slot `s`:
    - If `mask_q[s]` and `req[s]`: `gnt[s]`=1 and `dout_dv`=1.
    - If `mask_q[s]` and not `req[s]`: no grant, `dout_dv`=0, underrun event.
    - If `mask_q[s]`=0: no grant, `dout_dv`=0, no event.
  - `dout_chn`=`s` every RUN/DRAIN cycle, whether or not the slot is valid.
  - `sync_out`=1 on slot 0 when `sync_pend` is set; `sync_pend` clears at that time.
  - `sync_pend` is set by LOAD, by `resync`, or when the round counter reaches SYNC_PERIOD-1 at `s`=SIZE-1 (only if SYNC_PERIOD>0). The round counter resets whenever sync fires.
  - `resync` in the same cycle as the slot-0 sync both fires and re-arms, so the next round also syncs.
  - `en`=0 sampled in RUN moves to DRAIN.
- **DRAIN**
  - Continues RUN behaviour until the slot SIZE-1 cycle completes, then moves to IDLE. Partial rounds are never emitted.
  - If already at `s`=SIZE-1 when `en` drops, IDLE follows immediately.
  - `en` re-asserted during DRAIN is ignored. IDLE then moves to LOAD on the next cycle.
- **Underrun counting**
  - `underrun_cnt` increments by 1 per event and saturates at 0xFFFF.
  - It is cleared only by reset.

## Timing
- Reset values: `gnt`=0, `dout_dv`=0, `dout_chn`=0, `sync_out`=0, `busy`=0, `underrun_cnt`=0. FSM=IDLE, `mask_q`=0, `sync_pend`=0, round counter=0.
- Reset assertion mid-round clears everything asynchronously. There is no drain.
- All outputs are registered.
  - `req`/`mask_q` evaluated in cycle t drive `gnt`/`dout_dv`/`dout_chn`/`sync_out` in cycle t+1.
  - `gnt`, `dout_dv`, `dout_chn` and `sync_out` are mutually aligned.
- Start latency: `en` high at edge 0 puts LOAD in cycle 1, the first slot evaluated in cycle 2, and the first outputs (`chn`=0, `sync_out`=1) in cycle 3.
- `busy`=1 from LOAD through the last DRAIN output cycle.
- A channel buffer must drop or update `req` in the cycle after its `gnt`. It is sampled again only SIZE cycles later, so there is no hazard for SIZE≥2.
- Throughput: one slot per cycle, no bubbles between rounds.

## Configuration
- Macro: `PRACH_SCHED_UNDERRUN_CNT_EN`.
  - Defined: the underrun counter is implemented as described.
  - Undefined: the counter logic is removed and `underrun_cnt` is tied to 0. Scheduling behaviour is identical in both builds.

## Test plan
- **Start, full mask:** SIZE=8, `ch_mask`=0xFF, `req`=0xFF, `en` raised → from cycle 3, `dout_chn` 0..7 repeating, `dout_dv`=1 continuously, `gnt` walks one-hot 0x01..0x80, `sync_out` only on the first `chn`=0.
- **Mask change:** `ch_mask` 0xFF→0x0F written while `dout_chn`=3 → current round stays fully valid; from the next round `dout_dv`=1 only on `chn`0–3; `underrun_cnt` stays 0.
- **Underrun:** `ch_mask`=0xFF, `req`=0xFB for 3 rounds → no `gnt[2]`, `dout_dv`=0 on `chn`=2, `underrun_cnt`=3. Forcing 70000 events → counter reads 0xFFFF.
- **Periodic sync and resync:** SYNC_PERIOD=4 → `sync_out` on rounds 0, 4, 8. A `resync` pulse during round 5 → sync at round 6 start, then rounds 10, 14.
- **Stop:** `en` dropped while `dout_chn`=2 → outputs continue through `chn`=7, then `busy`=0 and no further `gnt`. Re-raising `en` during DRAIN → restart with sync after IDLE.
- **Reset:** `rst_n` asserted mid-round → all outputs 0 in the same cycle; after release, IDLE until `en`.
